// File: rtl/em_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// em_stall_ctrl_pkg
// Shared definitions for the FD/EM stall sequencer:
//   - FSM state encoding (RUN / MEM_WAIT / ERR, 2-bit)
//   - register-address and data widths of the pipeline
//   - NOP control bits forced into the EM register when a bubble is inserted
// ---------------------------------------------------------------------------
package em_stall_ctrl_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } em_state_e;

    // Control bits at the EM register inputs that a bubble overrides.
    typedef struct packed {
        logic gp_reg_wb;
        logic mem_we;
        logic mem_re;
    } em_ctrl_t;

    localparam em_ctrl_t EM_NOP_CTRL = '{gp_reg_wb: 1'b0, mem_we: 1'b0, mem_re: 1'b0};

endpackage

// File: rtl/em_stall_ctrl_stall_wait_counter.sv
// ---------------------------------------------------------------------------
// stall_wait_counter
// Counts MEM_WAIT cycles of the outstanding data-memory request and flags
// when the count has reached TIMEOUT.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset (count -> 0)
//   clr    in   synchronous clear (takes priority over inc)
//   inc    in   increment by one
//   tc     out  terminal count: count == TIMEOUT
// ---------------------------------------------------------------------------
module stall_wait_counter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/em_stall_ctrl.sv
// ---------------------------------------------------------------------------
// em_stall_ctrl
// Hazard and stall sequencer for the FD/EM pipeline register. Detects the
// load-use hazard at load completion, runs the data-memory req/ack handshake
// and raises a sticky watchdog error if a request waits too long.
//
// Optional feature macro: EM_STALL_CTRL_PERF_CNT_EN
//   defined   -> stall_cycles counts clocks with em_stall=1 (saturating)
//   undefined -> stall_cycles tied to 0, no counter flops
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   fd_valid                   FD holds a real instruction
//   fd_rs1/fd_rs2 (+ _used)    FD source registers and whether they are read
//   em_rd, em_reg_wb           EM destination and register-write enable
//   em_mem_re, em_mem_we       EM instruction is a load / store
//   mem_ack                    memory completes the request this cycle
//   mem_req                    memory request
//   em_stall                   stall for the FD/EM register
//   fd_hold                    freeze PC and FD
//   em_bubble                  force NOP control bits into EM
//   timeout_err                sticky watchdog flag
//   stall_cycles               performance count of stalled cycles
// ---------------------------------------------------------------------------
module em_stall_ctrl
    import em_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PERF_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fd_valid,
    input  logic [REG_ADDR_W-1:0] fd_rs1,
    input  logic [REG_ADDR_W-1:0] fd_rs2,
    input  logic                  fd_rs1_used,
    input  logic                  fd_rs2_used,
    input  logic [REG_ADDR_W-1:0] em_rd,
    input  logic                  em_reg_wb,
    input  logic                  em_mem_re,
    input  logic                  em_mem_we,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  em_stall,
    output logic                  fd_hold,
    output logic                  em_bubble,
    output logic                  timeout_err,
    output logic [PERF_W-1:0]     stall_cycles
);

    em_state_e state_q;
    em_state_e state_d;

    logic mem_op;
    logic lu_hz;
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_tc;
    logic mem_req_c;
    logic stall_c;
    logic bubble_c;
    logic err_c;

    assign mem_op = em_mem_re | em_mem_we;

    // Only a register-writing load can produce a value FD needs before
    // forwarding can supply it; unused sources never match.
    assign lu_hz = fd_valid & em_mem_re & em_reg_wb &
                   ((fd_rs1_used & (fd_rs1 == em_rd)) |
                    (fd_rs2_used & (fd_rs2 == em_rd)));

    stall_wait_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        mem_req_c = 1'b0;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        err_c     = 1'b0;
        case (state_q)
            RUN: begin
                mem_req_c = mem_op;
                stall_c   = mem_op & ~mem_ack;
                // Bubble only on load completion: while stalled the FD/EM
                // register is frozen and nothing new enters EM.
                bubble_c  = lu_hz & mem_ack;
                if (mem_op && !mem_ack) begin
                    state_d = MEM_WAIT;
                    cnt_inc = 1'b1;   // counter is 0 in RUN, so this loads 1
                end
            end
            MEM_WAIT: begin
                mem_req_c = 1'b1;
                stall_c   = ~mem_ack;
                bubble_c  = lu_hz & mem_ack;
                // Ack has priority over a coincident timeout match.
                if (mem_ack) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    state_d = ERR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ERR: begin
                stall_c = 1'b1;
                err_c   = 1'b1;
            end
            default: begin
                state_d = RUN;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by reset so they fall asynchronously when reset
    // asserts, even though the inputs may still present a memory op.
    assign mem_req     = reset & mem_req_c;
    assign em_stall    = reset & stall_c;
    assign em_bubble   = reset & bubble_c;
    assign fd_hold     = reset & (stall_c | bubble_c);
    assign timeout_err = reset & err_c;

`ifdef EM_STALL_CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q;
    logic [PERF_W-1:0] perf_d;

    always_comb begin
        perf_d = perf_q;
        if (em_stall && (perf_q != {PERF_W{1'b1}})) begin
            perf_d = perf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/em_stall_ctrl.md
Name: em_stall_ctrl

Overview:
- Hazard and stall sequencer for the fetch-decode / execute-memory pipeline register.
- Watches the memory operation latched in the EM stage and the source operands decoded in FD.
- Drives the EM register `stall`, an FD hold, and a bubble-insert strobe.
- Runs the request/acknowledge handshake with data memory, with a wait-timeout watchdog.

Parameters:
- TIMEOUT, 255: MEM_WAIT cycles without mem_ack before entering ERR; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the wait counter.
- PERF_W, 16: width of the stall-cycle performance counter (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fd_valid  in  1  FD stage holds a real instruction.
- fd_rs1, fd_rs2  in  3 each  FD source register addresses.
- fd_rs1_used, fd_rs2_used  in  1 each  the FD instruction reads that source.
- em_rd  in  3  EM stage destination register address.
- em_reg_wb  in  1  EM instruction writes the register file.
- em_mem_re  in  1  EM instruction is a LOAD.
- em_mem_we  in  1  EM instruction is a STORE.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- em_stall  out  1  drives the stall input of the FD/EM register.
- fd_hold  out  1  freezes PC and the FD stage.
- em_bubble  out  1  forces gp_reg_wb/mem_we/mem_re at the EM register inputs to 0.
- timeout_err  out  1  sticky watchdog flag.
- stall_cycles  out  PERF_W  performance count (only with PERF_CNT_EN).

Behaviour:
- Reset (reset=0, async):
  - state=RUN, wait_cnt=0, timeout_err=0, stall_cycles=0.
  - All combinational outputs evaluate to 0 while in reset.
- Definitions:
  - mem_op = em_mem_re | em_mem_we.
  - lu_hz = fd_valid & em_mem_re & em_reg_wb & ((fd_rs1_used & fd_rs1==em_rd) | (fd_rs2_used & fd_rs2==em_rd)).
- States: RUN, MEM_WAIT, ERR (2-bit encoding).
- RUN:
  - mem_req = mem_op; em_stall = mem_op & ~mem_ack; fd_hold = em_stall | em_bubble.
  - em_bubble = lu_hz & mem_ack, i.e. the load completes, FD holds one cycle, and a NOP enters EM.
  - mem_op & ~mem_ack -> MEM_WAIT, wait_cnt <= 1. Otherwise stay in RUN.
- MEM_WAIT:
  - mem_req = 1; em_stall = ~mem_ack; fd_hold = em_stall | em_bubble; em_bubble = lu_hz & mem_ack.
  - mem_ack -> RUN, wait_cnt <= 0. Stall drops in the same cycle as ack; zero-cycle ack in RUN means no stall at all.
  - ~mem_ack & wait_cnt==TIMEOUT -> ERR.
  - Otherwise wait_cnt <= wait_cnt+1.
- ERR:
  - em_stall = fd_hold = 1; mem_req = 0; em_bubble = 0; timeout_err = 1.
  - Exit only through reset; mem_ack is ignored.
- Load-use is evaluated only in the cycle the load completes. While em_stall=1 the FD/EM register is frozen, so no bubble is issued.
- Forwarding from the stage after EM resolves everything else; this block stalls nothing except load-use and memory wait.
- em_rd with em_reg_wb=0 never creates a hazard. Unused sources never create a hazard.
- mem_ack while mem_op=0 in RUN is ignored.
- Simultaneous ack and timeout-count match in MEM_WAIT: ack wins, next state is RUN.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, and mem_req drops asynchronously.

Optional Feature:
- Macro: EM_STALL_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every clock with em_stall=1, saturating at 2^PERF_W-1.
  - Cleared only by reset.
- Undefined:
  - stall_cycles is tied to 0 and no counter flops exist.
  - All other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding localparams RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2;
  - the register-address width (3) and data width (10);
  - the NOP control-bit constants used for bubble insertion.
- One natural sub-module: stall_wait_counter (CNT_W-bit counter with clear, increment, and terminal-count compare against TIMEOUT).
- Hazard compare logic stays inline.

Test Plan:
- Store in EM with mem_ack=1 in the same cycle -> mem_req=1, em_stall=0, fd_hold=0, no state change.
- Load r3 in EM, ack after 3 cycles, FD reads r5 -> em_stall=1 for 3 cycles, drops on the ack cycle, em_bubble=0.
- Load r3 with immediate ack, FD fd_rs2=3 with fd_rs2_used=1 -> em_bubble=1 and fd_hold=1 for exactly 1 cycle; with fd_rs2_used=0 -> no bubble.
- TIMEOUT=4, load never acked -> ERR after 4 MEM_WAIT cycles; timeout_err=1 and mem_req=0 until reset.
- Assert reset low during MEM_WAIT between clock edges -> all outputs 0 immediately; after release, state is RUN and wait_cnt=0.
- With EM_STALL_CTRL_PERF_CNT_EN: three separate 2-cycle waits -> stall_cycles=6; without the macro, stall_cycles=0.
